// File: rtl/ahb_imem_rom.sv
// ahb_imem_rom: AHB-Lite read-only instruction memory slave.
// Pipelined address/data phases, programmable wait states before each OKAY
// data phase, and a two-cycle ERROR response for illegal accesses.
// ROM contents come from a built-in constant boot image.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS - address phase: select, byte address, transfer type
//   HWRITE, HSIZE       - write flag (always illegal), transfer size
//   HREADY              - bus ready qualifying the address phase
//   HRDATA, HREADYOUT, HRESP - registered data phase response
module ahb_imem_rom #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = "imem.hex"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int unsigned OFFS       = (DATA_W == 64) ? 3 : 2;
    localparam logic [31:0] ALIGN_MASK = 32'((1 << OFFS) - 1);
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic [31:0]       offs;
    logic [31:0]       idx;
    logic              capture;
    logic              legal;
    logic [DATA_W-1:0] rom_rd;

    // ROM image lookup
    function automatic logic [DATA_W-1:0] rom_word(input logic [31:0] i);
        logic [31:0] w;
        case (i)
            32'd0:   w = 32'h0020_81b3;
            32'd1:   w = 32'h4021_8233;
            32'd2:   w = 32'h0020_c2b3;
            32'd3:   w = 32'h0020_e333;
            32'd4:   w = 32'h0020_f3b3;
            default: w = NOP;
        endcase
        return DATA_W'(w);
    endfunction

    assign rom_rd = rom_word(idx);

    logic unused_cfg;
    assign unused_cfg = ^{HTRANS[0], (INIT_FILE != "")};

    // Address decode and legality; below-base wrap is caught by the explicit compare
    always_comb begin
        offs    = HADDR - BASE_ADDR;
        idx     = offs >> OFFS;
        capture = HSEL & HREADY & HTRANS[1];
        legal   = !HWRITE
                  && (HSIZE == 3'(OFFS))
                  && ((HADDR & ALIGN_MASK) == 32'd0)
                  && (HADDR >= BASE_ADDR)
                  && (idx < DEPTH);
    end

    // Next state and registered output decode
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rd_d    = rd_q;

        case (state_q)
            ST_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // HREADYOUT is high here, so a new address phase may land
                state_d = ST_IDLE;
                if (capture) begin
                    if (legal) begin
                        rd_d = rom_rd;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_WAIT;
                            wcnt_d  = 4'(WAIT_STATES);
                        end
                    end else begin
                        state_d = ST_ERR1;
                    end
                end
            end
        endcase

        hreadyout_d = !(state_d inside {ST_WAIT, ST_ERR1});
        hresp_d     = (state_d inside {ST_ERR1, ST_ERR2});
        hrdata_d    = (state_d == ST_DATA) ? rd_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            rd_q        <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rd_q        <= rd_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_imem_rom.sv
// tb_ahb_imem_rom: scoreboard bench for two ahb_imem_rom instances.
// dut0: default parameters. dut1: BASE_ADDR=0x1000, DEPTH=40, WAIT_STATES=3.
// The driver pushes the expected response of each captured transfer into a
// per-instance queue; a negedge monitor compares every cycle's outputs.
module tb_ahb_imem_rom;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    localparam logic [31:0] BASE1  = 32'h0000_1000;
    localparam int          DEPTH1 = 40;
    localparam int          WAIT1  = 3;

    typedef struct {
        int          cap;
        bit          err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int drv_timeout = 0;
    bit mon_en = 1'b0;
    bit final_chk = 1'b0;
    bit final_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ahb_imem_rom u_dut0 (
        .clk(clk), .reset(reset),
        .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HREADY(hreadyout[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_imem_rom #(
        .DEPTH(DEPTH1), .BASE_ADDR(BASE1), .WAIT_STATES(WAIT1)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HREADY(hreadyout[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    // Reference: what the slave must answer for one captured transfer
    function automatic exp_t model(input int k, input logic [31:0] a, input logic wr,
                                   input logic [2:0] sz, input int cap);
        logic [31:0] boot [5];
        logic [31:0] base;
        int          depth;
        longint      word;
        exp_t        e;
        boot[0] = 32'h002081b3; boot[1] = 32'h40218233; boot[2] = 32'h0020c2b3;
        boot[3] = 32'h0020e333; boot[4] = 32'h0020f3b3;
        base  = (k == 0) ? 32'h0 : BASE1;
        depth = (k == 0) ? 64 : DEPTH1;
        e.cap   = cap;
        e.waits = (k == 0) ? 0 : WAIT1;
        e.data  = 32'h0;
        e.err   = 1'b1;
        if (!wr && sz == 3'd2 && (a % 4) == 0 && a >= base) begin
            word = longint'(a - base) / 4;
            if (word < longint'(depth)) begin
                e.err  = 1'b0;
                e.data = (word < 5) ? boot[int'(word)] : 32'h0000_0013;
            end
        end
        return e;
    endfunction

    // Present one address phase once the slave is ready; record it if captured
    task automatic issue(input int k, input logic sel, input logic [31:0] a,
                         input logic [1:0] tr, input logic wr, input logic [2:0] sz);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk); #1;
        while (hreadyout[k] !== 1'b1 && guard < 40) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 40) drv_timeout++;
        hsel[k]   = sel;
        haddr[k]  = a;
        htrans[k] = tr;
        hwrite[k] = wr;
        hsize[k]  = sz;
        if (sel && tr[1]) begin
            e = model(k, a, wr, sz, cyc + 1);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic rd(input int k, input logic [31:0] a, input logic [1:0] tr);
        issue(k, 1'b1, a, tr, 1'b0, 3'd2);
    endtask

    task automatic idle(input int k);
        issue(k, 1'b0, 32'h0, T_IDLE, 1'b0, 3'd2);
    endtask

    task automatic check_dut(input int k);
        exp_t        e;
        bit          have;
        bit          last;
        int          rel;
        logic [33:0] act;
        logic [33:0] want;
        have = 1'b0;
        last = 1'b0;
        want = {1'b1, 1'b0, 32'h0};
        if (k == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (have && e.cap <= cyc) begin
            rel = cyc - e.cap;
            if (e.err) begin
                want = (rel == 0) ? {1'b0, 1'b1, 32'h0} : {1'b1, 1'b1, 32'h0};
                last = (rel >= 1);
            end else begin
                want = (rel < e.waits) ? {1'b0, 1'b0, 32'h0} : {1'b1, 1'b0, e.data};
                last = (rel >= e.waits);
            end
        end
        act = {hreadyout[k], hresp[k], hrdata[k]};
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL resp dut%0d cyc %0d: got rdy=%0b resp=%0b data=%08h, want rdy=%0b resp=%0b data=%08h",
                     k, cyc, act[33], act[32], act[31:0], want[33], want[32], want[31:0]);
        end
        if (last) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    // Monitor: every cycle's response against the scoreboard head
    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0);
            check_dut(1);
        end
        if (final_chk && !final_done) begin
            n_cmp++;
            if (q0.size() != 0 || q1.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
            end
            n_cmp++;
            if (drv_timeout != 0) begin
                n_bad++;
                $display("FAIL ready_timeout: got %0d timeouts, want 0", drv_timeout);
            end
            final_done = 1'b1;
        end
    end

    task automatic rand_xfer(input int k);
        logic [31:0] base;
        logic [31:0] a;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic        sel;
        logic        wr;
        int          depth;
        int          t;
        int          m;
        base  = (k == 0) ? 32'h0 : BASE1;
        depth = (k == 0) ? 64 : DEPTH1;
        sel = ($urandom_range(0, 99) < 90);
        t = $urandom_range(0, 9);
        tr = (t == 0) ? T_IDLE : (t == 1) ? T_BUSY : (t < 6) ? T_NSEQ : T_SEQ;
        a = base + 32'($urandom_range(0, depth + 3)) * 32'd4;
        m = $urandom_range(0, 19);
        if (m == 0) a = base - 32'd4 * 32'($urandom_range(1, 3));
        if (m == 1) a = a | 32'($urandom_range(1, 3));
        if (m == 2) a = $urandom;
        wr = ($urandom_range(0, 9) == 0);
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        issue(k, sel, a, tr, wr, sz);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hsel[k] = 1'b0; haddr[k] = 32'h0; htrans[k] = T_IDLE;
            hwrite[k] = 1'b0; hsize[k] = 3'd2;
        end
        reset = 1'b1;
        @(negedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        // Back-to-back pipelined reads, zero wait
        rd(0, 32'h0, T_NSEQ); rd(0, 32'h4, T_SEQ); rd(0, 32'h8, T_SEQ); idle(0);
        // Illegal accesses and boundaries
        issue(0, 1'b1, 32'h4, T_NSEQ, 1'b1, 3'd2);
        rd(0, 32'h2, T_NSEQ);
        issue(0, 1'b1, 32'h0, T_NSEQ, 1'b0, 3'd1);
        rd(0, 32'h100, T_NSEQ);
        rd(0, 32'hFC, T_NSEQ);
        issue(0, 1'b1, 32'h0, T_IDLE, 1'b0, 3'd2);
        issue(0, 1'b1, 32'h8, T_BUSY, 1'b0, 3'd2);
        issue(0, 1'b0, 32'h8, T_NSEQ, 1'b0, 3'd2);
        idle(0);

        // Wait states and base offset
        rd(1, BASE1 + 32'h10, T_NSEQ);
        rd(1, BASE1 - 32'h4, T_NSEQ);
        rd(1, BASE1, T_NSEQ);
        rd(1, BASE1 + 32'(4 * (DEPTH1 - 1)), T_NSEQ);
        rd(1, BASE1 + 32'(4 * DEPTH1), T_NSEQ);
        idle(1);

        // Reset in the second wait cycle drops the transfer
        rd(1, BASE1 + 32'h10, T_NSEQ);
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            hsel[k] = 1'b0; htrans[k] = T_IDLE;
        end
        @(negedge clk); #1;
        reset = 1'b0;
        rd(1, BASE1 + 32'h4, T_NSEQ);
        idle(1);

        // Randomized traffic on both instances
        for (int k = 0; k < 2; k++) begin
            repeat (250) rand_xfer(k);
            idle(k);
        end

        repeat (10) @(negedge clk);
        #1 final_chk = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_imem_rom.md
Name: ahb_imem_rom

Overview:
- Parametrised AHB-Lite read-only instruction memory slave for the RISC-V SoC; sits on the instruction-fetch AHB port behind the decoder's HSEL.
- Adds the following over the fixed 5-entry ROM:
  - configurable depth, data width and base address;
  - true address/data-phase pipelining;
  - programmable wait states;
  - two-cycle AHB ERROR response for illegal accesses.

Parameters:
- DATA_W, 32, data/instruction word width; 32 or 64 only.
- DEPTH, 64, number of ROM words; power of two not required.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted before each OKAY data phase; range 0..15.
- INIT_FILE, "imem.hex", hex image name, used only with IMEM_INIT_FILE_EN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- HSEL  in  1  slave select from AHB decoder
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  write flag; any write is illegal
- HSIZE  in  3  transfer size
- HREADY  in  1  bus-wide ready, qualifies the address phase
- HRDATA  out  DATA_W  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Definitions:
  - OFFS = log2(DATA_W/8); idx = (HADDR - BASE_ADDR) >> OFFS.
  - Capture occurs on a rising edge when HSEL & HREADY & HTRANS[1].
  - IDLE/BUSY transfers, or transfers with HSEL low, are never captured and cause an OKAY zero-wait response.
- Legality at capture:
  - HWRITE = 0;
  - HSIZE = OFFS;
  - HADDR[OFFS-1:0] = 0;
  - HADDR >= BASE_ADDR;
  - idx < DEPTH.
  - Any failure is an error.
- Legal capture: rom[idx] is registered into rd_q at the capture edge.
- States and outputs:
  - ST_IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - ST_WAIT: HREADYOUT=0, HRESP=0, HRDATA=0; counter wcnt decrements each cycle.
  - ST_DATA: HREADYOUT=1, HRESP=0, HRDATA=rd_q.
  - ST_ERR1: HREADYOUT=0, HRESP=1, HRDATA=0.
  - ST_ERR2: HREADYOUT=1, HRESP=1, HRDATA=0.
- Transitions from ST_IDLE, ST_DATA and ST_ERR2 (HREADYOUT high, so a new address phase may be captured):
  - legal capture and WAIT_STATES=0 -> ST_DATA;
  - legal capture and WAIT_STATES>0 -> ST_WAIT, wcnt=WAIT_STATES;
  - illegal capture -> ST_ERR1;
  - no capture -> ST_IDLE.
- ST_WAIT: if wcnt==1 -> ST_DATA, else stay with wcnt-1. This gives exactly WAIT_STATES low cycles.
- ST_ERR1 -> ST_ERR2 unconditionally.
- Error handling ignores WAIT_STATES: an error is always exactly 2 cycles.
- Latency:
  - read data is presented 1+WAIT_STATES cycles after the capture edge;
  - with WAIT_STATES=0, back-to-back SEQ reads sustain 1 word per cycle, with the next address captured during the current data phase.
- Captures are not evaluated in ST_WAIT or ST_ERR1. HREADY is low in those states by construction; an HREADY glitch there is ignored.
- Reset:
  - At the next rising edge with reset=1: state -> ST_IDLE, wcnt=0, rd_q=0, HREADYOUT=1, HRESP=0, HRDATA=0.
  - An in-flight transfer is dropped with no response; this includes reset asserted in ST_WAIT or ST_ERR1.
  - ROM contents are constant and are not affected by reset.
- Outputs are registered state decodes only; there are no combinational paths from inputs to outputs.
- Subtraction HADDR - BASE_ADDR is 32-bit unsigned. The range check uses HADDR >= BASE_ADDR explicitly, so wrap-around below the base is always an error.
- The top valid word is idx=DEPTH-1 (OKAY); idx=DEPTH is an error.

Optional Feature:
- Macro: IMEM_INIT_FILE_EN.
- Defined: ROM contents are loaded at elaboration from INIT_FILE via hex read. Words not covered by the file read 0x00000013 (NOP).
- Undefined: built-in boot image, with DATA_W=32 words:
  - [0]=0x002081b3, [1]=0x40218233, [2]=0x0020c2b3, [3]=0x0020e333, [4]=0x0020f3b3;
  - all remaining words = 0x00000013.
  - For DATA_W=64, each word is the zero-extended 32-bit value.

Test Plan:
1. Defaults, macro undefined; after reset, NONSEQ read at HADDR=0x0, then SEQ reads at 0x4 and 0x8 -> HRDATA=0x002081b3, 0x40218233, 0x0020c2b3 on three consecutive cycles; HREADYOUT stays 1; HRESP=0.
2. WAIT_STATES=3; NONSEQ read at 0x10 -> HREADYOUT low for exactly 3 cycles, then HRDATA=0x0020f3b3 with HREADYOUT=1 and HRESP=0.
3. Illegal accesses:
   - write to 0x4 -> HRESP=1 with HREADYOUT=0 on the first cycle, then HRESP=1 with HREADYOUT=1; HRDATA=0.
   - repeat for HADDR=0x2 (misaligned), HSIZE=1, and HADDR=0x100 (idx=64=DEPTH) -> same two-cycle ERROR.
   - read at 0xFC (idx=63) -> OKAY with 0x00000013.
4. BASE_ADDR=0x1000; read at 0x0FFC -> ERROR; read at 0x1000 -> 0x002081b3.
5. WAIT_STATES=2; assert reset during the second wait cycle -> next edge gives HREADYOUT=1, HRESP=0, HRDATA=0 with no data phase; a fresh read at 0x4 then returns 0x40218233.
6. IDLE, then BUSY transfer with HSEL=1, and NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout; no state change.
